booth_mul_arbiter: RTL and testbench

- Shares one booth_multiplier instance between two requesters, e.g. two issue ports of the integer pipe.
- Arbitrates requests round-robin into a registered issue stage and sign- or zero-extends the 32-bit operands to the multiplier's 33-bit inputs.
- Records the owner of every in-flight operation in an in-order tag FIFO, and routes each 64-bit result back to the requester that issued it.

---
 rtl/booth_mul_arbiter.sv | 152 +++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// Two-requester front end for a shared booth_multiplier: round-robin issue stage,
// operand sign/zero extension, and an in-order owner FIFO that routes results back.
module booth_mul_arbiter #(
  parameter int XLEN    = 32,
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid_i,
  output logic [1:0]                 req_ready_o,
  input  logic [2*XLEN-1:0]          req_a_i,
  input  logic [2*XLEN-1:0]          req_b_i,
  input  logic [1:0]                 req_signed_i,
  input  logic [2*ID_W-1:0]          req_id_i,
  output logic                       mul_valid_o,
  input  logic                       mul_ready_i,
  output logic [XLEN:0]              mul_data1_o,
  output logic [XLEN:0]              mul_data2_o,
  input  logic                       mul_valid_i,
  output logic                       mul_ready_o,
  input  logic [2*XLEN-1:0]          mul_res_i,
  output logic [1:0]                 resp_valid_o,
  input  logic [1:0]                 resp_ready_i,
  output logic [2*XLEN-1:0]          resp_res_o,
  output logic [ID_W-1:0]            resp_id_o,
  output logic [$clog2(MAX_OUT):0]   outstanding_o,
  output logic                       err_o
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int OW = PW + 1;

  typedef struct packed {
    logic            owner;
    logic [ID_W-1:0] id;
  } tag_t;

  logic            stage_valid;
  logic            stage_owner;
  logic [ID_W-1:0] stage_id;
  logic [XLEN:0]   stage_d1;
  logic [XLEN:0]   stage_d2;

  tag_t            fifo_mem [MAX_OUT];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [OW-1:0]   fifo_cnt;
  tag_t            head;
  logic            fifo_nonempty;

  logic            last_grant;
  logic            err_q;

  logic [1:0]      grant;
  logic            gnt_idx;
  logic            stage_pop;
  logic            res_pop;
  logic            stage_free;
  logic            accept;
  logic [OW-1:0]   outstanding;
  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;
  logic            sel_sgn;

  // Round robin: on conflict the requester not granted last wins.
  always_comb begin
    grant = 2'b00;
    case (req_valid_i)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign gnt_idx       = grant[1];
  assign sel_a         = req_a_i[gnt_idx*XLEN +: XLEN];
  assign sel_b         = req_b_i[gnt_idx*XLEN +: XLEN];
  assign sel_sgn       = req_signed_i[gnt_idx];

  assign head          = fifo_mem[rd_ptr];
  assign fifo_nonempty = (fifo_cnt != '0);
  assign outstanding   = OW'(stage_valid) + fifo_cnt;

  assign stage_pop  = !rst && stage_valid && mul_ready_i;
  assign res_pop    = !rst && mul_valid_i && fifo_nonempty && resp_ready_i[head.owner];
  assign stage_free = !stage_valid || stage_pop;

  // At the cap, a new op may only replace one leaving the stage while a result leaves too.
  assign accept = !rst && (grant != 2'b00) &&
                  ((stage_free && (outstanding < OW'(MAX_OUT))) ||
                   ((outstanding == OW'(MAX_OUT)) && stage_pop && res_pop));

  assign req_ready_o   = accept ? grant : 2'b00;
  assign mul_valid_o   = !rst && stage_valid;
  assign mul_data1_o   = stage_d1;
  assign mul_data2_o   = stage_d2;
  assign resp_res_o    = mul_res_i;
  assign resp_id_o     = head.id;
  assign outstanding_o = outstanding;
  assign err_o         = err_q;

  always_comb begin
    resp_valid_o = 2'b00;
    mul_ready_o  = 1'b0;
    if (!rst) begin
      if (fifo_nonempty) begin
        mul_ready_o               = resp_ready_i[head.owner];
        resp_valid_o[head.owner]  = mul_valid_i;
      end else begin
        // Orphan result: swallow it so the multiplier cannot wedge.
        mul_ready_o = mul_valid_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      last_grant  <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        stage_valid <= 1'b1;
        stage_owner <= gnt_idx;
        stage_id    <= req_id_i[gnt_idx*ID_W +: ID_W];
        stage_d1    <= {sel_sgn & sel_b[XLEN-1], sel_b};
        stage_d2    <= {sel_sgn & sel_a[XLEN-1], sel_a};
        last_grant  <= gnt_idx;
      end else if (stage_pop) begin
        stage_valid <= 1'b0;
      end
      if (stage_pop) wr_ptr <= wr_ptr + PW'(1);
      if (res_pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({stage_pop, res_pop})
        2'b10:   fifo_cnt <= fifo_cnt + OW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - OW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (mul_valid_i && !fifo_nonempty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (stage_pop) fifo_mem[wr_ptr] <= '{owner: stage_owner, id: stage_id};
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Randomized bench for booth_mul_arbiter; the bench also plays the multiplier
// (fixed 2-cycle latency) and scores against a queue-based transaction model.
module tb_booth_mul_arbiter;
  localparam int XLEN = 32, ID_W = 4, MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_signed;
  logic [63:0] req_a, req_b;
  logic [7:0]  req_id;
  logic        mul_valid_o, mul_ready_in, mul_valid_in, mul_ready_o;
  logic [32:0] mul_data1, mul_data2;
  logic [63:0] mul_res, resp_res;
  logic [1:0]  resp_valid, resp_ready;
  logic [3:0]  resp_id;
  logic [2:0]  outstanding;
  logic        err;

  always #5 clk = ~clk;

  booth_mul_arbiter #(.XLEN(XLEN), .ID_W(ID_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_a_i(req_a), .req_b_i(req_b),
    .req_signed_i(req_signed), .req_id_i(req_id),
    .mul_valid_o(mul_valid_o), .mul_ready_i(mul_ready_in),
    .mul_data1_o(mul_data1), .mul_data2_o(mul_data2),
    .mul_valid_i(mul_valid_in), .mul_ready_o(mul_ready_o), .mul_res_i(mul_res),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_res_o(resp_res),
    .resp_id_o(resp_id), .outstanding_o(outstanding), .err_o(err)
  );

  typedef struct {
    logic        owner;
    logic [3:0]  id;
    logic [31:0] a, b;
    logic        sgn;
  } op_t;
  typedef struct {
    logic [63:0] res;
    int          rdy;
  } mop_t;

  op_t  stage_q[$];
  op_t  fifo_q[$];
  mop_t mq[$];
  logic [1:0] gnt_log[$];
  int   cyc = 0;
  bit   m_err = 0, last = 1, inject = 0;
  int   checks = 0, failures = 0;

  logic [1:0]  obs_req_ready, obs_resp_valid, resp_seen;
  logic        obs_mul_ready;
  logic [32:0] last_d1, last_d2;
  logic [63:0] last_res;
  logic [3:0]  last_id;
  logic        last_owner;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [32:0] ext(input logic [31:0] v, input logic s);
    return {s & v[31], v};
  endfunction

  function automatic logic [63:0] prod(input op_t o);
    longint sa, sb;
    sa = o.sgn ? longint'($signed(o.a)) : longint'(o.a);
    sb = o.sgn ? longint'($signed(o.b)) : longint'(o.b);
    return 64'(sa * sb);
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(3))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock: entered at negedge with inputs set; leaves at the next negedge.
  task automatic step();
    bit sp, fne, rp, exp_mrdy, acc;
    int out;
    logic [1:0] g, exp_rv;
    op_t n;
    mop_t m;
    logic signed [65:0] x, y, p;
    mul_valid_in = inject || (mq.size() > 0 && mq[0].rdy <= cyc);
    mul_res      = inject ? 64'hDEAD_BEEF_0BAD_F00D : (mq.size() > 0 ? mq[0].res : 64'h0);
    #1;
    obs_req_ready = req_ready; obs_resp_valid = resp_valid; obs_mul_ready = mul_ready_o;
    resp_seen |= resp_valid;
    if (rst) begin
      chk("rst_quiet", 64'({req_ready, mul_valid_o, mul_ready_o, resp_valid}), 64'h0);
      stage_q.delete(); fifo_q.delete(); mq.delete();
      m_err = 0; last = 1;
    end else begin
      fne      = fifo_q.size() > 0;
      sp       = stage_q.size() > 0 && mul_ready_in;
      exp_mrdy = fne ? resp_ready[fifo_q[0].owner] : mul_valid_in;
      rp       = mul_valid_in && fne && exp_mrdy;
      out      = stage_q.size() + fifo_q.size();
      case (req_valid)
        2'b01:   g = 2'b01;
        2'b10:   g = 2'b10;
        2'b11:   g = last ? 2'b01 : 2'b10;
        default: g = 2'b00;
      endcase
      acc = (g != 2'b00) && ((((stage_q.size() == 0) || sp) && out < MAX_OUT) ||
                             (out == MAX_OUT && sp && rp));
      exp_rv = (mul_valid_in && fne) ? (fifo_q[0].owner ? 2'b10 : 2'b01) : 2'b00;

      chk("req_ready", 64'(req_ready), 64'(acc ? g : 2'b00));
      chk("mul_valid", 64'(mul_valid_o), 64'(stage_q.size() > 0));
      if (stage_q.size() > 0) begin
        chk("data1", 64'(mul_data1), 64'(ext(stage_q[0].b, stage_q[0].sgn)));
        chk("data2", 64'(mul_data2), 64'(ext(stage_q[0].a, stage_q[0].sgn)));
      end
      if (mul_valid_in) chk("mul_ready", 64'(mul_ready_o), 64'(exp_mrdy));
      chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
      if (exp_rv != 2'b00) begin
        chk("resp_id", 64'(resp_id), 64'(fifo_q[0].id));
        chk("resp_res", resp_res, prod(fifo_q[0]));
      end
      chk("outstanding", 64'(outstanding), 64'(out));
      chk("err", 64'(err), 64'(m_err));

      if (rp) begin
        last_res = resp_res; last_id = resp_id; last_owner = resp_valid[1];
        void'(fifo_q.pop_front()); void'(mq.pop_front());
      end
      if (mul_valid_in && !fne) m_err = 1;
      if (sp) begin
        last_d1 = mul_data1; last_d2 = mul_data2;
        x = $signed(mul_data1); y = $signed(mul_data2); p = x * y;
        m.res = p[63:0]; m.rdy = cyc + 2;
        mq.push_back(m);
        fifo_q.push_back(stage_q.pop_front());
      end
      if (acc) begin
        n.owner = g[1];
        n.a   = g[1] ? req_a[63:32] : req_a[31:0];
        n.b   = g[1] ? req_b[63:32] : req_b[31:0];
        n.sgn = g[1] ? req_signed[1] : req_signed[0];
        n.id  = g[1] ? req_id[7:4] : req_id[3:0];
        stage_q.push_back(n);
        gnt_log.push_back(g);
        last = g[1];
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((stage_q.size() > 0 || fifo_q.size() > 0) && n < limit) begin
      step(); n++;
    end
    if (n >= limit) chk("drain_timeout", 64'(n), 64'(limit + 1));
  endtask

  task automatic one_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] id);
    req_valid = 2'b01; req_a = {32'h0, a}; req_b = {32'h0, b};
    req_signed = {1'b0, s}; req_id = {4'h0, id};
    step();
    req_valid = 2'b00;
    drain(20);
  endtask

  initial begin
    rst = 1; req_valid = 0; req_a = 0; req_b = 0; req_signed = 0; req_id = 0;
    mul_ready_in = 1; mul_valid_in = 0; mul_res = 0; resp_ready = 2'b11;
    resp_seen = 0;
    @(negedge clk);
    step(); step();
    rst = 0;
    chk("rst_out", 64'(outstanding), 64'h0);
    chk("rst_err", 64'(err), 64'h0);

    // signed and unsigned extension of the same operands
    one_op(32'hFFFF_FFFD, 32'h7, 1'b1, 4'h3);
    chk("s_d2", 64'(last_d2), 64'h1_FFFF_FFFD);
    chk("s_d1", 64'(last_d1), 64'h0_0000_0007);
    chk("s_res", last_res, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("s_id", 64'(last_id), 64'h3);
    chk("s_owner", 64'(last_owner), 64'h0);
    one_op(32'hFFFF_FFFD, 32'h7, 1'b0, 4'h5);
    chk("u_d2", 64'(last_d2), 64'h0_FFFF_FFFD);
    chk("u_res", last_res, 64'h0000_0006_FFFF_FFEB);

    // contention: r0 won last, so r1 takes the first conflict
    gnt_log.delete();
    req_valid = 2'b11; req_signed = 2'b10;
    for (int i = 0; i < 40 && gnt_log.size() < 8; i++) begin
      req_a = {pick32(), pick32()}; req_b = {pick32(), pick32()}; req_id = 8'($urandom);
      step();
    end
    req_valid = 2'b00;
    chk("rr_count", 64'(gnt_log.size()), 64'd8);
    if (gnt_log.size() > 0) chk("rr_first", 64'(gnt_log[0]), 64'(2'b10));
    for (int i = 1; i < gnt_log.size(); i++)
      chk("rr_alt", 64'(gnt_log[i]), 64'(gnt_log[i-1] == 2'b01 ? 2'b10 : 2'b01));
    drain(30);

    // multiplier backpressure
    mul_ready_in = 0; req_valid = 2'b01; req_a = 64'h1234; req_b = 64'h5678; req_signed = 0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_blocked", 64'(obs_req_ready), 64'h0);
    mul_ready_in = 1;
    step();
    chk("bp_resume", 64'(obs_req_ready), 64'(2'b01));
    req_valid = 2'b00;
    drain(30);

    // fill to the cap with responses stalled, then swap one in/one out
    resp_ready = 2'b00; req_valid = 2'b01;
    for (int i = 0; i < 20 && (stage_q.size() + fifo_q.size()) < MAX_OUT; i++) begin
      req_a = {32'h0, pick32()}; req_b = {32'h0, pick32()}; req_signed = 2'($urandom);
      step();
    end
    mul_ready_in = 0;
    step();
    chk("full_out", 64'(outstanding), 64'd4);
    chk("full_block", 64'(obs_req_ready), 64'h0);
    mul_ready_in = 1; resp_ready = 2'b11;
    step();
    chk("full_swap_acc", 64'(obs_req_ready), 64'(2'b01));
    chk("full_swap_out", 64'(outstanding), 64'd4);
    req_valid = 2'b00;
    drain(30);

    // reset with three in flight, then an orphan result
    resp_ready = 2'b00; req_valid = 2'b01;
    for (int i = 0; i < 20 && (stage_q.size() + fifo_q.size()) < 3; i++) step();
    req_valid = 2'b00; resp_ready = 2'b11;
    rst = 1; step(); rst = 0;
    chk("mid_rst_out", 64'(outstanding), 64'h0);
    resp_seen = 0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_rst_noresp", 64'(resp_seen), 64'h0);
    inject = 1; step(); inject = 0;
    chk("orphan_ready", 64'(obs_mul_ready), 64'h1);
    chk("orphan_noresp", 64'(obs_resp_valid), 64'h0);
    chk("orphan_err", 64'(err), 64'h1);
    step();
    chk("err_sticky", 64'(err), 64'h1);
    rst = 1; step(); rst = 0;
    chk("err_clear", 64'(err), 64'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom); req_signed = 2'($urandom); req_id = 8'($urandom);
      req_a = {pick32(), pick32()}; req_b = {pick32(), pick32()};
      mul_ready_in = ($urandom_range(3) != 0);
      resp_ready = 2'($urandom) | 2'($urandom);
      step();
    end
    req_valid = 2'b00; mul_ready_in = 1; resp_ready = 2'b11;
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
